instr_fetch_unit: RTL

- Front-end stage directly upstream of the cpu core; produces the `instruction` word the core decodes.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to the core on a valid/ready interface.
- Accepts branch/jump redirects from the core, flushing stale fetches.

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack fetch FSM, prefetch FIFO, redirect flush.
// Optional IFU_MISALIGN_CHECK_EN adds a sticky fetch_fault output for misaligned redirect targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    addr_q, addr_d;
    logic [CW-1:0]  count_q, count_after;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0]    mem_data_q [FIFO_DEPTH];
    logic [31:0]    mem_pc_q   [FIFO_DEPTH];

    logic           push, pop, flush, can_issue;
    logic [31:0]    redir_pc;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign fault_d     = fault_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    assign can_issue   = !fault_q;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fault_q <= 1'b0;
        else      fault_q <= fault_d;
    end
`else
    assign can_issue = 1'b1;
`endif

    assign imem_req   = (state_q != S_IDLE);
    assign imem_addr  = addr_q;
    assign fetch_pc   = fetch_pc_q;
    assign inst_valid = (count_q != '0) && !redirect_valid;
    assign inst_data  = (count_q != '0) ? mem_data_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = (count_q != '0) ? mem_pc_q[rd_ptr_q]   : 32'h0;
    assign pop        = inst_valid && inst_ready;

    // occupancy once this cycle's push and pop have landed; decides back-to-back issue
    assign count_after = count_q + CW'(1) - {{(CW-1){1'b0}}, pop};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = redirect_valid;
        if (redirect_valid) fetch_pc_d = redir_pc;
        case (state_q)
            S_IDLE: begin
                if (!redirect_valid && (count_q < DEPTH_C) && can_issue) begin
                    addr_d  = fetch_pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if ((count_after < DEPTH_C) && can_issue) begin
                            addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            if (flush) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            end
        end
    end

    // storage needs no reset: outputs are gated by count_q
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_data_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule
